softex_stream_buffer: RTL

SOFTEX_STREAM_BUFFER -- requirements
Module: softex_stream_buffer

---
 rtl/softex_stream_buffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/softex_stream_buffer.sv
// Multi-channel stream buffer: one circular FIFO per input channel, merged onto a
// single output by a round-robin arbiter. Optional macro SOFTEX_BUFFER_FALLTHROUGH_EN
// lets an empty channel forward its input word combinationally with zero latency.
module softex_stream_buffer #(
    parameter  int unsigned DATA_WIDTH = 256,
    parameter  int unsigned DEPTH      = 4,
    parameter  int unsigned N_CH       = 2,
    localparam int unsigned CW         = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned OW         = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [N_CH-1:0]            in_valid_i,
    output logic [N_CH-1:0]            in_ready_o,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic [CW-1:0]              out_ch_o,
    output logic [N_CH*OW-1:0]         count_o,
    output logic [N_CH-1:0]            empty_o,
    output logic [N_CH-1:0]            full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [N_CH][DEPTH];
    logic [AW-1:0]         wptr_q [N_CH];
    logic [AW-1:0]         rptr_q [N_CH];
    logic [OW-1:0]         cnt_q  [N_CH];

    logic [CW-1:0]         rr_q;
    logic                  hold_q;
    logic [CW-1:0]         hold_ch_q;

    logic [N_CH-1:0]       empty;
    logic [N_CH-1:0]       full;
    logic [N_CH-1:0]       ready;
    logic [N_CH-1:0]       push;
    logic [N_CH-1:0]       pop;
    logic [N_CH-1:0]       elig;
    logic [N_CH-1:0]       wr_en;
    logic [N_CH-1:0]       rd_en;
    logic                  gnt_vld;
    logic [CW-1:0]         gnt_ch;
    logic                  pop_any;
    logic [DATA_WIDTH-1:0] head;

    always_comb begin
        empty   = '0;
        full    = '0;
        ready   = '0;
        push    = '0;
        elig    = '0;
        count_o = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            empty[c] = (cnt_q[c] == '0);
            full[c]  = (cnt_q[c] == OW'(DEPTH));
            ready[c] = ~full[c] & ~clear_i;
            push[c]  = in_valid_i[c] & ready[c];
`ifdef SOFTEX_BUFFER_FALLTHROUGH_EN
            elig[c]  = ~empty[c] | push[c];
`else
            elig[c]  = ~empty[c];
`endif
            count_o[c*OW +: OW] = cnt_q[c];
        end
    end

    assign in_ready_o = ready;
    assign empty_o    = empty;
    assign full_o     = full;

    // A stalled grant is locked so the presented word cannot change under the consumer.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_ch  = rr_q;
        if (hold_q) begin
            gnt_ch  = hold_ch_q;
            gnt_vld = elig[hold_ch_q];
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                idx = int'(rr_q) + i;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                if (!gnt_vld && elig[CW'(idx)]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = CW'(idx);
                end
            end
        end
    end

    always_comb begin
        head = mem_q[gnt_ch][rptr_q[gnt_ch]];
`ifdef SOFTEX_BUFFER_FALLTHROUGH_EN
        if (empty[gnt_ch]) begin
            head = in_data_i[gnt_ch*DATA_WIDTH +: DATA_WIDTH];
        end
`endif
        out_valid_o = gnt_vld;
        out_ch_o    = gnt_ch;
        out_data_o  = gnt_vld ? head : '0;
    end

    assign pop_any = gnt_vld & out_ready_i & ~clear_i;

    always_comb begin
        pop   = '0;
        wr_en = '0;
        rd_en = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            pop[c]   = pop_any && (gnt_ch == CW'(c));
            wr_en[c] = push[c];
            rd_en[c] = pop[c];
`ifdef SOFTEX_BUFFER_FALLTHROUGH_EN
            // Word forwarded straight through an empty channel is never stored.
            if (empty[c] && push[c] && pop[c]) begin
                wr_en[c] = 1'b0;
                rd_en[c] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            rr_q      <= '0;
            hold_q    <= 1'b0;
            hold_ch_q <= '0;
        end else if (clear_i) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            rr_q      <= '0;
            hold_q    <= 1'b0;
            hold_ch_q <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (wr_en[c]) begin
                    wptr_q[c] <= wptr_q[c] + AW'(1);
                end
                if (rd_en[c]) begin
                    rptr_q[c] <= rptr_q[c] + AW'(1);
                end
                if (wr_en[c] && !rd_en[c]) begin
                    cnt_q[c] <= cnt_q[c] + OW'(1);
                end else if (!wr_en[c] && rd_en[c]) begin
                    cnt_q[c] <= cnt_q[c] - OW'(1);
                end
            end
            if (pop_any) begin
                rr_q <= (gnt_ch == CW'(N_CH - 1)) ? '0 : gnt_ch + CW'(1);
            end
            hold_q    <= gnt_vld & ~out_ready_i;
            hold_ch_q <= gnt_ch;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (wr_en[c]) begin
                mem_q[c][wptr_q[c]] <= in_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
